// File: rtl/route_pkg.sv
// rtl/route_pkg.sv - shared destination codes and FSM state encoding for route_arbiter
package route_pkg;

  localparam logic [1:0] DEST_SELF  = 2'b01;
  localparam logic [1:0] DEST_LEFT  = 2'b00;
  localparam logic [1:0] DEST_RIGHT = 2'b10;
  localparam logic [1:0] DEST_BAD   = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DROP = 2'd2
  } state_t;

endpackage

// File: rtl/rr_pick3.sv
// rtl/rr_pick3.sv - combinational three-way round-robin pick starting after the last winner
module rr_pick3 (
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic [2:0] win_onehot,
  output logic [1:0] win_idx
);

  // Walk the rotation from lowest to highest priority so the highest-priority requester overrides
  always_comb begin
    win_onehot = 3'b000;
    win_idx    = 2'd0;
    for (int k = 3; k >= 1; k--) begin
      int i;
      i = (int'(last) + k) % 3;
      if (req[i]) begin
        win_onehot    = 3'b000;
        win_onehot[i] = 1'b1;
        win_idx       = 2'(i);
      end
    end
  end

endmodule

// File: rtl/route_arbiter.sv
// rtl/route_arbiter.sv - round-robin arbiter and sequencer for the shared master_spi instruction path
module route_arbiter
  import route_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [2:0]           req,
  input  logic [3*WIDTH-1:0]   req_instr,
  input  logic [5:0]           req_dest,
  output logic [2:0]           gnt,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_instr,
  output logic [1:0]           out_dest,
  input  logic                 out_ready,
  output logic                 drop_err,
  output logic                 busy,
  output logic [CNT_W-1:0]     cnt_self,
  output logic [CNT_W-1:0]     cnt_left,
  output logic [CNT_W-1:0]     cnt_right
);

  state_t             state, state_nxt;
  logic [1:0]         last;
  logic [2:0]         win_oh;
  logic [1:0]         win_idx;
  logic [WIDTH-1:0]   sel_instr;
  logic [1:0]         sel_dest;
  logic               arb_fire;

  rr_pick3 u_pick (
    .req        (req),
    .last       (last),
    .win_onehot (win_oh),
    .win_idx    (win_idx)
  );

  assign arb_fire = (state == IDLE) && (req != 3'b000);

  // Steer the winning requester's instruction and destination onto the latch inputs
  always_comb begin
    sel_instr = req_instr[0 +: WIDTH];
    sel_dest  = req_dest[1:0];
    case (win_idx)
      2'd1: begin
        sel_instr = req_instr[WIDTH +: WIDTH];
        sel_dest  = req_dest[3:2];
      end
      2'd2: begin
        sel_instr = req_instr[2*WIDTH +: WIDTH];
        sel_dest  = req_dest[5:4];
      end
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: an illegal destination costs one DROP cycle, everything else waits in SEND for ready
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (arb_fire) state_nxt = (sel_dest == DEST_BAD) ? DROP : SEND;
      SEND: if (out_ready) state_nxt = IDLE;
      DROP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs decode straight from the state register, so they carry no input path
  assign out_valid = (state == SEND);
  assign drop_err  = (state == DROP);
  assign busy      = (state != IDLE);

  // Grant pulse, winner latch and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt       <= 3'b000;
      last      <= 2'd2;
      out_instr <= '0;
      out_dest  <= 2'b00;
    end else begin
      gnt <= 3'b000;
      if (arb_fire) begin
        gnt       <= win_oh;
        last      <= win_idx;
        out_instr <= sel_instr;
        out_dest  <= sel_dest;
      end
    end
  end

  // Per-destination completed-transfer counters, bumped on the accepting edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_self  <= '0;
      cnt_left  <= '0;
      cnt_right <= '0;
    end else if ((state == SEND) && out_ready) begin
      case (out_dest)
        DEST_SELF:  cnt_self  <= cnt_self  + CNT_W'(1);
        DEST_LEFT:  cnt_left  <= cnt_left  + CNT_W'(1);
        DEST_RIGHT: cnt_right <= cnt_right + CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule
